bus_fifo_responder: RTL and testbench
=====================================

Name: bus_fifo_responder

Overview:
- Memory-mapped 8-bit FIFO peripheral on the main CPU bus (BUS_ADDR/BUS_DATA/BUS_WE). It is the responder side of the processor's bus transactions.
- The CPU pushes bytes by writing and pops bytes by reading.
- It raises an interrupt to the CPU via the BUS_INTERRUPT_RAISE/ACK handshake when the fill level reaches a programmable threshold.
- Used as a software-visible byte queue between interrupt handlers and the main loop.

Parameters:
- BASE_ADDR, 8'hB0, base of the 3-address register window (BASE..BASE+2).
- DEPTH, 8, FIFO entries; power of two, 2..8, so that count fits in 4 bits.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- BUS_ADDR  input  8  main bus address.
- BUS_DATA  inout  8  main bus data; driven only during a read of this block, else high-Z.
- BUS_WE  input  1  bus write enable; 1 = CPU write, 0 = read.
- BUS_INTERRUPT_RAISE  output  1  interrupt request to CPU.
- BUS_INTERRUPT_ACK  input  1  interrupt acknowledge from CPU.

Behaviour:
- Register map:
  - BASE+0 DATA: write = push, read = pop.
  - BASE+1 STATUS. Read value = {full, empty, ovf, unf, count[3:0]}. Write: bit0 = 1 clears ovf/unf; bit1 = 1 flushes (count = 0, pointers = 0).
  - BASE+2 THR: R/W, bits [3:0] used; reads return {4'b0, thr}.
- Reset (RESET = 0, immediate, asynchronous):
  - BUS_DATA high-Z, BUS_INTERRUPT_RAISE = 0.
  - count = 0, read/write pointers = 0, ovf = unf = 0, thr = 0, read-active flag = 0.
  - FIFO storage contents are don't-care.
- match = (BUS_ADDR in BASE..BASE+2).
- Write: every clock with BUS_WE = 1 and match performs one register write.
  - Push to a full FIFO: data dropped, pointers unchanged, ovf set (sticky).
- Read latency:
  - Edge t samples match & !BUS_WE.
  - The block drives BUS_DATA from after edge t until the first edge where match & !BUS_WE is false; it then releases to Z after that edge.
  - The drive-enable register is recomputed every edge.
- Read access start: the first cycle of match & !BUS_WE at BASE+0 when the previous cycle was not a read of BASE+0.
  - Exactly one pop per contiguous read access, however many cycles the CPU holds the address.
  - The popped byte is latched and held on BUS_DATA for the whole access.
  - Pop when empty: returns 8'h00, pointers unchanged, unf set (sticky).
- STATUS/THR reads return the value sampled at each edge.
- Pointers: DEPTH is a power of two, so pointers wrap naturally modulo DEPTH.
  - count increments on accepted push, decrements on accepted pop.
  - full = (count == DEPTH); empty = (count == 0).
- Push and pop in the same cycle cannot occur (single bus). Flush takes priority over any pending state in its cycle.
- Interrupt:
  - cond = (thr != 0) && (count >= thr); cond_prev is registered.
  - RAISE is set on the edge where cond & !cond_prev, and held until the edge where ACK = 1 is sampled, then cleared.
  - If a new rising cond and ACK occur in the same cycle, set wins (RAISE stays 1).
  - cond held high does not re-raise after ACK; the level must drop and rise again.
  - Writing thr so that cond becomes true counts as a rising edge.
- Asserting reset mid-read releases BUS_DATA to Z immediately and discards FIFO contents.

Test Plan:
- Reset: RESET = 0 then 1 -> BUS_DATA = Z, RAISE = 0; read BASE+1 -> 8'h40 (empty = 1, count = 0).
- Order: write 8'h11, 8'h22, 8'h33 to 8'hB0, then three 3-cycle reads of 8'hB0 -> 8'h11, 8'h22, 8'h33, each held constant for all driven cycles; STATUS then reads 8'h40.
- Full/overflow: 9 pushes of 8'h01..8'h09 -> STATUS = 8'hA8 (full, ovf, count 8); 8 pops return 8'h01..8'h08; a 9th pop returns 8'h00 and STATUS = 8'h70 (empty, ovf, unf); write 8'h01 to 8'hB1 -> STATUS = 8'h40.
- Wrap: repeated push/pop of 20 bytes through DEPTH = 8 -> data order preserved, count never exceeds 1.
- Interrupt: THR = 3; push 3 bytes -> RAISE goes 1 on the edge after the 3rd push; ACK pulse -> RAISE = 0; a 4th push gives no re-raise; pop to 2 then push to 3 -> RAISE again.
- Flush/simultaneity: push 5 bytes, write 8'h02 to 8'hB1 -> count = 0; RAISE asserted with ACK sampled on the same edge as a new rising cond -> RAISE remains 1.

Source files
------------

// File: rtl/bus_fifo_responder.sv
// bus_fifo_responder
//   Memory-mapped byte FIFO on the main CPU bus. The CPU pushes by writing
//   BASE+0 and pops by reading it; STATUS (BASE+1) reports fill state and
//   sticky error flags; THR (BASE+2) sets the fill level that raises an
//   interrupt through the RAISE/ACK handshake.
//
// Ports
//   CLK                  system clock, rising edge
//   RESET                asynchronous reset, active low
//   BUS_ADDR[7:0]        bus address
//   BUS_DATA[7:0]        bidirectional bus data, driven only while read
//   BUS_WE               1 = CPU write, 0 = CPU read
//   BUS_INTERRUPT_RAISE  interrupt request to the CPU
//   BUS_INTERRUPT_ACK    interrupt acknowledge from the CPU
//
// Register map
//   BASE+0 DATA   write = push, read = pop (one pop per contiguous access)
//   BASE+1 STATUS read {full, empty, ovf, unf, count[3:0]};
//                 write bit0 = clear ovf/unf, bit1 = flush
//   BASE+2 THR    bits [3:0], reads back {4'b0, thr}

module bus_fifo_responder #(
    parameter logic [7:0] BASE_ADDR = 8'hB0,
    parameter int         DEPTH     = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BUS_ADDR,
    inout  wire  [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [3:0]       count;
    logic [3:0]       thr;
    logic             ovf;
    logic             unf;
    logic             rd_active;
    logic             drive_en;
    logic             cond_prev;
    logic [7:0]       rd_data;

    logic [7:0] offset;
    logic       match;
    logic       wr_en;
    logic       rd_en;
    logic       full;
    logic       empty;
    logic       push;
    logic       do_push;
    logic       pop_start;
    logic       do_pop;
    logic       flush;
    logic       clr_err;
    logic       cond;
    logic [7:0] status;

    // Unsigned subtraction wraps, so a window near the top of the address
    // space still decodes correctly with a single compare.
    assign offset  = BUS_ADDR - BASE_ADDR;
    assign match   = (offset < 8'd3);
    assign wr_en   = match && BUS_WE;
    assign rd_en   = match && !BUS_WE;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == 4'd0);
    assign status  = {full, empty, ovf, unf, count};

    assign push    = wr_en && (offset == 8'd0);
    assign do_push = push && !full;
    // rd_active remembers that the previous cycle already read DATA, so a
    // CPU holding the address for several cycles pops only once.
    assign pop_start = rd_en && (offset == 8'd0) && !rd_active;
    assign do_pop    = pop_start && !empty;

    assign flush   = wr_en && (offset == 8'd1) && BUS_DATA[1];
    assign clr_err = wr_en && (offset == 8'd1) && BUS_DATA[0];

    assign cond    = (thr != 4'd0) && (count >= thr);

    assign BUS_DATA = drive_en ? rd_data : 8'hzz;

    // Control state: pointers, level, flags, bus drive and interrupt.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wptr                <= '0;
            rptr                <= '0;
            count               <= 4'd0;
            thr                 <= 4'd0;
            ovf                 <= 1'b0;
            unf                 <= 1'b0;
            rd_active           <= 1'b0;
            drive_en            <= 1'b0;
            cond_prev           <= 1'b0;
            BUS_INTERRUPT_RAISE <= 1'b0;
        end else begin
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= 4'd0;
            end else if (do_push) begin
                wptr  <= wptr + PTR_W'(1);
                count <= count + 4'd1;
            end else if (do_pop) begin
                rptr  <= rptr + PTR_W'(1);
                count <= count - 4'd1;
            end

            if (clr_err) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end else begin
                if (push && full)
                    ovf <= 1'b1;
                if (pop_start && empty)
                    unf <= 1'b1;
            end

            if (wr_en && (offset == 8'd2))
                thr <= BUS_DATA[3:0];

            rd_active <= rd_en && (offset == 8'd0);
            drive_en  <= rd_en;
            cond_prev <= cond;

            // A fresh rising level beats a simultaneous acknowledge.
            if (cond && !cond_prev)
                BUS_INTERRUPT_RAISE <= 1'b1;
            else if (BUS_INTERRUPT_ACK)
                BUS_INTERRUPT_RAISE <= 1'b0;
        end
    end

    // Storage and read-data latch carry no reset; their contents are only
    // observed once the control state says they are valid.
    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wptr] <= BUS_DATA;

        if (rd_en) begin
            case (offset)
                8'd0: begin
                    if (pop_start)
                        rd_data <= empty ? 8'h00 : mem[rptr];
                end
                8'd1:    rd_data <= status;
                default: rd_data <= {4'b0000, thr};
            endcase
        end
    end

endmodule

// File: tb/tb_bus_fifo_responder.sv
module tb_bus_fifo_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic       we;
    logic       ack;
    logic [7:0] cpu_data;
    logic       cpu_drive;
    logic       raise;
    wire  [7:0] bus_data;

    int checks = 0;
    int errors = 0;

    // Pull-ups make a released bus read as 8'hFF; no test byte uses 8'hFF.
    for (genvar g = 0; g < 8; g++) begin : g_pull
        pullup pu (bus_data[g]);
    end

    assign bus_data = cpu_drive ? cpu_data : 8'hzz;

    always #5 clk = ~clk;

    bus_fifo_responder #(.BASE_ADDR(8'hB0), .DEPTH(8)) dut (
        .CLK                 (clk),
        .RESET               (rst),
        .BUS_ADDR            (a),
        .BUS_DATA            (bus_data),
        .BUS_WE              (we),
        .BUS_INTERRUPT_RAISE (raise),
        .BUS_INTERRUPT_ACK   (ack)
    );

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        a = addr; we = 1'b1; cpu_data = data; cpu_drive = 1'b1;
        @(negedge clk);
        a = 8'h00; we = 1'b0; cpu_drive = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, input int ncyc,
                            output logic [7:0] first, output logic stable);
        logic [7:0] v;
        @(negedge clk);
        a = addr; we = 1'b0;
        stable = 1'b1;
        first = 8'h00;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            v = bus_data;
            if (i == 0) first = v;
            else if (v !== first) stable = 1'b0;
        end
        a = 8'h00;
    endtask

    task automatic test_reset();
        logic [7:0] v; logic s;
        rst = 1'b0; a = 8'h00; we = 1'b0; ack = 1'b0; cpu_data = 8'h00; cpu_drive = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus_data !== 8'hFF) begin errors++; $display("FAIL reset_bus got %h want released(ff)", bus_data); end
        checks++; if (raise !== 1'b0) begin errors++; $display("FAIL reset_raise got %b want 0", raise); end
        rst = 1'b1;
        bus_read(8'hB1, 1, v, s);
        checks++; if (v !== 8'h40) begin errors++; $display("FAIL reset_status got %h want 40", v); end
    endtask

    task automatic test_order();
        logic [7:0] v; logic s;
        logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) bus_write(8'hB0, exp[i]);
        for (int i = 0; i < 3; i++) begin
            bus_read(8'hB0, 3, v, s);
            checks++; if (v !== exp[i]) begin errors++; $display("FAIL order_data[%0d] got %h want %h", i, v, exp[i]); end
            checks++; if (s !== 1'b1) begin errors++; $display("FAIL order_hold[%0d] got unstable want stable %h", i, exp[i]); end
        end
        @(negedge clk);
        checks++; if (bus_data !== 8'hFF) begin errors++; $display("FAIL order_release got %h want released(ff)", bus_data); end
        bus_read(8'hB1, 1, v, s);
        checks++; if (v !== 8'h40) begin errors++; $display("FAIL order_status got %h want 40", v); end
    endtask

    task automatic test_full_overflow();
        logic [7:0] v; logic s;
        for (int i = 1; i <= 9; i++) bus_write(8'hB0, 8'(i));
        bus_read(8'hB1, 1, v, s);
        checks++; if (v !== 8'hA8) begin errors++; $display("FAIL full_status got %h want a8", v); end
        for (int i = 1; i <= 8; i++) begin
            bus_read(8'hB0, 2, v, s);
            checks++; if (v !== 8'(i)) begin errors++; $display("FAIL full_pop[%0d] got %h want %h", i, v, 8'(i)); end
        end
        bus_read(8'hB0, 2, v, s);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL underflow_data got %h want 00", v); end
        bus_read(8'hB1, 1, v, s);
        checks++; if (v !== 8'h70) begin errors++; $display("FAIL underflow_status got %h want 70", v); end
        bus_write(8'hB1, 8'h01);
        bus_read(8'hB1, 1, v, s);
        checks++; if (v !== 8'h40) begin errors++; $display("FAIL clear_status got %h want 40", v); end
    endtask

    task automatic test_wrap();
        logic [7:0] v; logic s;
        for (int i = 0; i < 20; i++) begin
            bus_write(8'hB0, 8'(8'h80 + i));
            bus_read(8'hB1, 1, v, s);
            checks++; if (v !== 8'h01) begin errors++; $display("FAIL wrap_status[%0d] got %h want 01", i, v); end
            bus_read(8'hB0, 1, v, s);
            checks++; if (v !== 8'(8'h80 + i)) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, v, 8'(8'h80 + i)); end
        end
        bus_read(8'hB1, 1, v, s);
        checks++; if (v !== 8'h40) begin errors++; $display("FAIL wrap_final got %h want 40", v); end
    endtask

    task automatic test_interrupt();
        logic [7:0] v; logic s;
        bus_write(8'hB2, 8'h03);
        bus_read(8'hB2, 1, v, s);
        checks++; if (v !== 8'h03) begin errors++; $display("FAIL thr_read got %h want 03", v); end
        bus_write(8'hB0, 8'hA1);
        bus_write(8'hB0, 8'hA2);
        checks++; if (raise !== 1'b0) begin errors++; $display("FAIL irq_below got %b want 0", raise); end
        bus_write(8'hB0, 8'hA3);
        checks++; if (raise !== 1'b0) begin errors++; $display("FAIL irq_early got %b want 0", raise); end
        @(posedge clk); #1;
        checks++; if (raise !== 1'b1) begin errors++; $display("FAIL irq_raise got %b want 1", raise); end
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        checks++; if (raise !== 1'b0) begin errors++; $display("FAIL irq_ack got %b want 0", raise); end
        bus_write(8'hB0, 8'hA4);
        repeat (2) @(negedge clk);
        checks++; if (raise !== 1'b0) begin errors++; $display("FAIL irq_no_reraise got %b want 0", raise); end
        bus_read(8'hB0, 1, v, s);
        bus_read(8'hB0, 1, v, s);
        checks++; if (v !== 8'hA2) begin errors++; $display("FAIL irq_pop got %h want a2", v); end
        bus_write(8'hB0, 8'hA5);
        @(posedge clk); #1;
        checks++; if (raise !== 1'b1) begin errors++; $display("FAIL irq_rerise got %b want 1", raise); end
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        checks++; if (raise !== 1'b0) begin errors++; $display("FAIL irq_ack2 got %b want 0", raise); end
    endtask

    task automatic test_flush_simultaneous();
        logic [7:0] v; logic s;
        bus_write(8'hB0, 8'hB6);
        bus_write(8'hB0, 8'hB7);
        bus_read(8'hB1, 1, v, s);
        checks++; if (v !== 8'h05) begin errors++; $display("FAIL flush_pre got %h want 05", v); end
        bus_write(8'hB1, 8'h02);
        bus_read(8'hB1, 1, v, s);
        checks++; if (v !== 8'h40) begin errors++; $display("FAIL flush_status got %h want 40", v); end
        bus_write(8'hB2, 8'h01);
        bus_write(8'hB0, 8'h61);
        @(posedge clk); #1;
        checks++; if (raise !== 1'b1) begin errors++; $display("FAIL sim_raise got %b want 1", raise); end
        bus_read(8'hB0, 1, v, s);
        checks++; if (v !== 8'h61) begin errors++; $display("FAIL sim_pop got %h want 61", v); end
        bus_write(8'hB0, 8'h62);
        ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        checks++; if (raise !== 1'b1) begin errors++; $display("FAIL sim_set_wins got %b want 1", raise); end
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        checks++; if (raise !== 1'b0) begin errors++; $display("FAIL sim_ack got %b want 0", raise); end
        bus_read(8'hB0, 1, v, s);
        checks++; if (v !== 8'h62) begin errors++; $display("FAIL sim_pop2 got %h want 62", v); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] v; logic s;
        bus_write(8'hB0, 8'h5A);
        @(negedge clk);
        a = 8'hB0; we = 1'b0;
        checks++; if (raise !== 1'b1) begin errors++; $display("FAIL mid_raise got %b want 1", raise); end
        @(negedge clk);
        checks++; if (bus_data !== 8'h5A) begin errors++; $display("FAIL mid_data got %h want 5a", bus_data); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus_data !== 8'hFF) begin errors++; $display("FAIL mid_release got %h want released(ff)", bus_data); end
        checks++; if (raise !== 1'b0) begin errors++; $display("FAIL mid_raise_clr got %b want 0", raise); end
        a = 8'h00;
        @(negedge clk); rst = 1'b1;
        bus_read(8'hB1, 1, v, s);
        checks++; if (v !== 8'h40) begin errors++; $display("FAIL mid_status got %h want 40", v); end
        bus_read(8'hB2, 1, v, s);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL mid_thr got %h want 00", v); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_order();
        test_full_overflow();
        test_wrap();
        test_interrupt();
        test_flush_simultaneous();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
